// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, opcodes, instruction field positions and IF FSM states.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   // Field LSB positions, shared with the decode stage.
   localparam int OPCODE_LSB = 0;
   localparam int RD_LSB     = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int RS1_LSB    = 15;
   localparam int RS2_LSB    = 20;
   localparam int FUNCT7_LSB = 25;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } if_state_t;

   function automatic logic is_misaligned(input logic [1:0] lsbs);
      return |lsbs;
   endfunction

endpackage

// File: rtl/if_buf.sv
// One-entry holding register for a fetched word and its PC; clear wins over load.
module if_buf #(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_clear,
   input  logic [D_WIDTH-1:0] i_word,
   input  logic [D_WIDTH-1:0] i_pc,
   output logic               o_full,
   output logic [D_WIDTH-1:0] o_word,
   output logic [D_WIDTH-1:0] o_pc
);

   logic               r_full;
   logic [D_WIDTH-1:0] r_word;
   logic [D_WIDTH-1:0] r_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full <= 1'b0;
         r_word <= '0;
         r_pc   <= '0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_word <= i_word;
         r_pc   <= i_pc;
      end
   end

   assign o_full = r_full;
   assign o_word = r_word;
   assign o_pc   = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, one-entry buffer, IF/ID register.
// Optional macro IF_ALIGN_CHK_EN: misaligned redirects raise fetch_fault and park the stage.
module if_stage
   import cpu_pkg::*;
#(
   parameter int                 D_WIDTH  = 32,
   parameter int                 N_REGS   = 32,
   parameter int                 RF_SIZE  = $clog2(N_REGS),
   parameter logic [D_WIDTH-1:0] PC_RESET = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               redirect,
   input  logic [D_WIDTH-1:0] redirect_pc,
   output logic               imem_req,
   output logic [D_WIDTH-1:0] imem_addr,
   input  logic               imem_rvalid,
   input  logic [D_WIDTH-1:0] imem_rdata,
   output logic               valid_id,
   output logic [D_WIDTH-1:0] pc_id,
   output logic [D_WIDTH-1:0] instr,
   output logic [RF_SIZE-1:0] rs1,
   output logic [RF_SIZE-1:0] rs2,
   output logic [RF_SIZE-1:0] rd,
   output logic [6:0]         opcode,
   output logic [2:0]         funct3,
   output logic [6:0]         funct7,
   output logic               fetch_fault
);

   localparam logic [D_WIDTH-1:0] PC_STEP    = D_WIDTH'(4);
   localparam logic [D_WIDTH-1:0] ALIGN_MASK = ~D_WIDTH'(3);

   if_state_t          r_state;
   if_state_t          w_state_next;
   logic [D_WIDTH-1:0] r_pc;
   logic [D_WIDTH-1:0] w_pc_next;
   logic               r_imem_req;
   logic               w_req_next;
   logic               r_fault;
   logic               w_fault_next;
   logic               w_redir_ok;
   logic [D_WIDTH-1:0] w_target_pc;
   logic               r_valid_id;
   logic [D_WIDTH-1:0] r_pc_id;
   logic [D_WIDTH-1:0] r_instr;
   logic               w_take_rsp;
   logic               w_issue;
   logic               w_buf_full;
   logic [D_WIDTH-1:0] w_buf_word;
   logic [D_WIDTH-1:0] w_buf_pc;
   logic               w_buf_load;
   logic               w_buf_clear;
   logic               w_from_buf;
   logic               w_deliver;

   assign w_take_rsp  = (r_state == WAIT) && imem_rvalid;
   assign w_issue     = (r_state == FETCH) && r_imem_req;
   assign w_from_buf  = (r_state == HOLD) && w_buf_full;
   assign w_deliver   = !redirect && en && (w_take_rsp || w_from_buf);
   assign w_buf_load  = !redirect && !en && w_take_rsp;
   assign w_buf_clear = redirect || ((r_state == HOLD) && en);
   assign w_target_pc = redirect_pc & ALIGN_MASK;

`ifdef IF_ALIGN_CHK_EN
   assign w_redir_ok   = redirect && !is_misaligned(redirect_pc[1:0]);
   assign w_fault_next = redirect ? is_misaligned(redirect_pc[1:0]) : r_fault;
`else
   assign w_redir_ok   = redirect;
   assign w_fault_next = 1'b0;
`endif

   if_buf #(.D_WIDTH(D_WIDTH)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_buf_load),
      .i_clear (w_buf_clear),
      .i_word  (imem_rdata),
      .i_pc    (r_pc),
      .o_full  (w_buf_full),
      .o_word  (w_buf_word),
      .o_pc    (w_buf_pc)
   );

   // Next-state: redirect overrides en; a request still in flight must be drained.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         FETCH: begin
            if (w_issue) begin
               w_state_next = redirect ? DRAIN : WAIT;
            end else begin
               w_state_next = FETCH;
            end
         end
         WAIT: begin
            if (redirect) begin
               w_state_next = imem_rvalid ? FETCH : DRAIN;
            end else if (imem_rvalid) begin
               w_state_next = en ? FETCH : HOLD;
            end else begin
               w_state_next = WAIT;
            end
         end
         HOLD: begin
            if (redirect || en) begin
               w_state_next = FETCH;
            end else begin
               w_state_next = HOLD;
            end
         end
         DRAIN: begin
            if (imem_rvalid) begin
               w_state_next = FETCH;
            end else begin
               w_state_next = DRAIN;
            end
         end
         default: w_state_next = FETCH;
      endcase
   end

   always_comb begin
      w_pc_next = r_pc;
      if (w_redir_ok) begin
         w_pc_next = w_target_pc;
      end else if (w_deliver) begin
         w_pc_next = r_pc + PC_STEP;
      end else begin
         w_pc_next = r_pc;
      end
   end

   // The request is registered one cycle ahead so it is high for exactly the FETCH cycle.
   assign w_req_next = (w_state_next == FETCH) && !w_fault_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= FETCH;
         r_pc       <= PC_RESET;
         r_imem_req <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_imem_req <= w_req_next;
         r_fault    <= w_fault_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid_id <= 1'b0;
         r_instr    <= D_WIDTH'(NOP_INSTR);
         r_pc_id    <= '0;
      end else if (redirect) begin
         r_valid_id <= 1'b0;
         r_instr    <= D_WIDTH'(NOP_INSTR);
      end else if (en) begin
         if (w_take_rsp) begin
            r_valid_id <= 1'b1;
            r_instr    <= imem_rdata;
            r_pc_id    <= r_pc;
         end else if (w_from_buf) begin
            r_valid_id <= 1'b1;
            r_instr    <= w_buf_word;
            r_pc_id    <= w_buf_pc;
         end else begin
            r_valid_id <= 1'b0;
            r_instr    <= D_WIDTH'(NOP_INSTR);
         end
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_pc;
   assign fetch_fault = r_fault;
   assign valid_id    = r_valid_id;
   assign pc_id       = r_pc_id;
   assign instr       = r_instr;
   assign opcode      = r_instr[OPCODE_LSB +: 7];
   assign rd          = r_instr[RD_LSB +: RF_SIZE];
   assign funct3      = r_instr[FUNCT3_LSB +: 3];
   assign rs1         = r_instr[RS1_LSB +: RF_SIZE];
   assign rs2         = r_instr[RS2_LSB +: RF_SIZE];
   assign funct7      = r_instr[FUNCT7_LSB +: 7];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for steady fetch/stall, hand sequences for redirect corners.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        valid_id;
   logic [31:0] pc_id;
   logic [31:0] instr;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        fetch_fault;

   int          checks;
   int          errors;
   bit          auto_mem;
   logic        pend_req;
   logic [31:0] pend_addr;

   typedef struct {
      logic        en;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc_id;
   } vec_t;

   vec_t tbl[9];

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .valid_id    (valid_id),
      .pc_id       (pc_id),
      .instr       (instr),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h0050_0093 ^ {a[9:2], 24'h00_0000};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock; with auto_mem the memory answers every request one cycle later.
   task automatic tick();
      pend_req  = imem_req;
      pend_addr = imem_addr;
      @(posedge clk);
      #1;
      if (auto_mem) begin
         imem_rvalid = pend_req;
         imem_rdata  = pend_req ? word_at(pend_addr) : 32'h0;
      end
   endtask

   task automatic check_req(input string tag, input logic r, input logic [31:0] addr);
      chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
      if (r) chk({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic check_id(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pcid);
      chk({tag, "_valid"}, {31'd0, valid_id}, {31'd0, v});
      chk({tag, "_instr"}, instr, ins);
      chk({tag, "_pc_id"}, pc_id, pcid);
      chk({tag, "_fields"}, {funct7, rs2, rs1, funct3, rd, opcode}, ins);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      auto_mem    = 1'b1;
      en          = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      rst         = 1'b1;
      #2 rst = 1'b0;

      tbl[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, NOP,           32'h0000_0000};
      tbl[1] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, NOP,           32'h0000_0000};
      tbl[2] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0050_0093, 32'h0000_0000};
      tbl[3] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0050_0093, 32'h0000_0000};
      tbl[4] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0050_0093, 32'h0000_0000};
      tbl[5] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0050_0093, 32'h0000_0000};
      tbl[6] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0150_0093, 32'h0000_0004};
      tbl[7] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, NOP,           32'h0000_0004};
      tbl[8] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0250_0093, 32'h0000_0008};

      tick();
      tick();
      check_req("reset", 1'b0, 32'h0);
      check_id("reset", 1'b0, NOP, 32'h0);
      chk("reset_fault", {31'd0, fetch_fault}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) begin
         en = tbl[i].en;
         tick();
         check_req($sformatf("row%0d", i), tbl[i].exp_req, tbl[i].exp_addr);
         check_id($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_instr, tbl[i].exp_pc_id);
      end
      chk("row2_rd_is_1", {27'd0, tbl[2].exp_instr[11:7]}, 32'd1);

      // Redirect while waiting, late word two cycles later.
      auto_mem    = 1'b0;
      imem_rvalid = 1'b0;
      en          = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      check_req("redir_wait", 1'b0, 32'h0);
      check_id("redir_wait", 1'b0, NOP, 32'h0000_0008);
      tick();
      check_req("drain_hold", 1'b0, 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      check_req("drain_done", 1'b1, 32'h0000_0100);
      check_id("drain_done", 1'b0, NOP, 32'h0000_0008);
      tick();
      imem_rvalid = 1'b1; imem_rdata = word_at(32'h0000_0100);
      tick();
      imem_rvalid = 1'b0;
      check_id("after_redir", 1'b1, 32'h4050_0093, 32'h0000_0100);
      check_req("after_redir", 1'b1, 32'h0000_0104);

      // Redirect in the same cycle as rvalid: no drain.
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hBAAD_F00D;
      redirect = 1'b1; redirect_pc = 32'h0000_0300;
      tick();
      imem_rvalid = 1'b0; redirect = 1'b0;
      check_req("redir_rvalid", 1'b1, 32'h0000_0300);
      check_id("redir_rvalid", 1'b0, NOP, 32'h0000_0100);

      // PC wrap from the top of the address space.
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      imem_rvalid = 1'b0; redirect = 1'b0;
      check_req("wrap_issue", 1'b1, 32'hFFFF_FFFC);
      tick();
      imem_rvalid = 1'b1; imem_rdata = word_at(32'hFFFF_FFFC);
      tick();
      imem_rvalid = 1'b0;
      check_id("wrap", 1'b1, 32'hFF50_0093, 32'hFFFF_FFFC);
      check_req("wrap", 1'b1, 32'h0000_0000);

      // Redirect while a request is issuing: drain the old response.
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      check_req("redir_fetch", 1'b0, 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
      tick();
      imem_rvalid = 1'b0;
      check_req("redir_fetch_done", 1'b1, 32'h0000_0040);
      check_id("redir_fetch_done", 1'b0, NOP, 32'hFFFF_FFFC);

      // Reset mid-transaction, then a stale rvalid before the first request.
      tick();
      rst = 1'b0;
      #1;
      check_req("midrst", 1'b0, 32'h0);
      check_id("midrst", 1'b0, NOP, 32'h0);
      tick();
      rst = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
      tick();
      imem_rvalid = 1'b0;
      check_req("late_rvalid", 1'b1, 32'h0000_0000);
      check_id("late_rvalid", 1'b0, NOP, 32'h0);
      tick();
      imem_rvalid = 1'b1; imem_rdata = word_at(32'h0);
      tick();
      imem_rvalid = 1'b0;
      check_id("post_rst", 1'b1, 32'h0050_0093, 32'h0);
      check_req("post_rst", 1'b1, 32'h0000_0004);

      // Misaligned redirect while a request is issuing.
      redirect = 1'b1; redirect_pc = 32'h0000_0102;
      tick();
      redirect = 1'b0;
      check_req("misal", 1'b0, 32'h0);
      check_id("misal", 1'b0, NOP, 32'h0);
`ifdef IF_ALIGN_CHK_EN
      chk("misal_fault", {31'd0, fetch_fault}, 32'd1);
      imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
      tick();
      imem_rvalid = 1'b0;
      check_req("parked", 1'b0, 32'h0);
      chk("parked_fault", {31'd0, fetch_fault}, 32'd1);
      tick();
      check_req("parked2", 1'b0, 32'h0);
      check_id("parked2", 1'b0, NOP, 32'h0);
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      chk("fault_clear", {31'd0, fetch_fault}, 32'd0);
      check_req("fault_clear", 1'b1, 32'h0000_0200);
`else
      chk("misal_fault", {31'd0, fetch_fault}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
      tick();
      imem_rvalid = 1'b0;
      check_req("misal_forced", 1'b1, 32'h0000_0100);
      chk("misal_forced_fault", {31'd0, fetch_fault}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC and issues word fetches to instruction memory over a req/rvalid handshake with one request outstanding.
- Holds a one-entry buffer for returned words and registers each instruction plus its field slices into the IF/ID pipeline register that feeds the decode stage.
- Supports downstream stall through en and PC redirect/flush from branch resolution.

Parameters:
- D_WIDTH, 32, instruction/PC/data width.
- N_REGS, 32, architectural register count.
- RF_SIZE, $clog2(N_REGS), register index width.
- PC_RESET, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  downstream advance; 0 = IF/ID register holds.
- redirect  in  1  flush and load new PC.
- redirect_pc  in  D_WIDTH  target PC.
- imem_req  out  1  fetch request, one-cycle pulse.
- imem_addr  out  D_WIDTH  fetch address, valid with imem_req.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  D_WIDTH  response word.
- valid_id  out  1  IF/ID holds a real instruction.
- pc_id  out  D_WIDTH  PC of instr.
- instr  out  D_WIDTH  instruction word.
- rs1  out  RF_SIZE  instr[19:15].
- rs2  out  RF_SIZE  instr[24:20].
- rd  out  RF_SIZE  instr[11:7].
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- fetch_fault  out  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Reset (rst=0, async): pc=PC_RESET, state=FETCH, buffer empty, valid_id=0, instr=NOP 32'h0000_0013, pc_id=0, imem_req=0, fetch_fault=0. Field outputs track instr, so they reset to the NOP fields.
- Reset asserted mid-operation:
  - The in-flight request is abandoned.
  - A late imem_rvalid arriving after reset release and before the first request is ignored.
- Field outputs are pure slices of the registered instr; there is no extra latency.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc; go to WAIT.
  - WAIT: await imem_rvalid.
    - rvalid & en: load IF/ID with {instr=rdata, pc_id=pc, valid_id=1}; pc+=4; go to FETCH.
    - rvalid & !en: capture into buffer; go to HOLD.
  - HOLD: buffer full.
    - en: move buffer to IF/ID; pc+=4; go to FETCH.
  - DRAIN: a discarded request is in flight. On rvalid, drop the word and go to FETCH.
- Throughput: one instruction per 2 cycles with 1-cycle memory; one request outstanding, never more.
- IF/ID update when en=1 and no instruction is available that cycle: bubble (valid_id=0, instr=NOP, pc_id unchanged).
- IF/ID when en=0: all outputs hold.
- pc is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 → 0).
- Redirect has highest priority and overrides en:
  - pc<=redirect_pc; IF/ID loads a bubble; buffer is cleared.
  - Next state by current state:
    - From WAIT with no rvalid this cycle: DRAIN.
    - From WAIT with rvalid in the same cycle: the word is discarded; FETCH.
    - From FETCH (request issuing this cycle): DRAIN.
    - From HOLD or DRAIN: FETCH (DRAIN stays DRAIN unless rvalid arrives the same cycle).
- imem_rvalid in FETCH or HOLD is a protocol error: ignored, no state change.

Optional Feature:
- Macro: IF_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 and does not load the PC or issue a fetch.
  - The stage parks in FETCH with imem_req suppressed and emits bubbles.
  - Only a subsequent aligned redirect or reset clears the fault.
- Undefined: fetch_fault tied 0; redirect_pc[1:0] forced to 0.

Decomposition:
- Shared package (cpu_pkg):
  - NOP_INSTR=32'h0000_0013.
  - Opcode constants (OP_IMM=7'b0010011, etc.).
  - Field bit-position constants shared with decode.
  - FSM state typedef if_state_t {FETCH, WAIT, HOLD, DRAIN}.
- Natural sub-module: if_buf, the one-entry word+PC holding register with full flag and clear.

Test Plan:
- Reset release, en=1, 1-cycle memory returning 32'h0050_0093 at 0 → imem_req pulses at addr 0, 4, 8 every 2 cycles; instr=32'h0050_0093, rd=1, opcode=7'h13, valid_id=1, pc_id=0.
- en=0 while word at addr 4 returns → state HOLD, IF/ID holds prior instr, no new imem_req; raise en → addr-4 word appears next edge, then imem_req addr 8.
- Redirect to 32'h0000_0100 while in WAIT, rvalid 2 cycles later → late word discarded, valid_id=0 for that cycle, next imem_addr=0x100.
- Redirect in the same cycle as rvalid → word dropped, next request at redirect_pc, no DRAIN entered.
- pc=32'hFFFF_FFFC fetch completes → next imem_addr=0.
- With IF_ALIGN_CHK_EN, redirect_pc=32'h0000_0102 → fetch_fault=1, no imem_req; then aligned redirect to 0x200 → fault clears, fetch at 0x200.
